// File: rtl/lsu_mem_if_pkg.sv
// rtl/lsu_mem_if_pkg.sv - shared types, constants and helpers for the load/store unit
package lsu_mem_if_pkg;

    localparam int BYTE_SIZE      = 8;
    localparam int HALF_WORD_SIZE = 16;

    typedef enum logic [2:0] {
        MEM_BYTE   = 3'd0,
        MEM_HALF   = 3'd1,
        MEM_WORD   = 3'd2,
        MEM_BYTE_U = 3'd3,
        MEM_HALF_U = 3'd4,
        MEM_WORD_U = 3'd5,
        MEM_DWORD  = 3'd6
    } mem_op_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ0  = 3'd1,
        WAIT0 = 3'd2,
        REQ1  = 3'd3,
        WAIT1 = 3'd4,
        RESP  = 3'd5
    } lsu_state_e;

    // Access size in bytes.
    function automatic logic [3:0] mem_op_size(input mem_op_e op);
        case (op)
            MEM_BYTE, MEM_BYTE_U: mem_op_size = 4'd1;
            MEM_HALF, MEM_HALF_U: mem_op_size = 4'd2;
            MEM_DWORD:            mem_op_size = 4'd8;
            default:              mem_op_size = 4'd4;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_if_if.sv
// rtl/lsu_mem_if_if.sv - request/grant data-memory bus between the LSU and memory
// Signals: mem_req/mem_gnt handshake, mem_addr/mem_we/mem_be/mem_wdata beat fields,
//          mem_rvalid/mem_rdata/mem_err beat response. master = LSU, slave = memory.
interface lsu_mem_if_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  mem_req;
    logic                  mem_gnt;
    logic [ADDR_W-1:0]     mem_addr;
    logic                  mem_we;
    logic [DATA_W/8-1:0]   mem_be;
    logic [DATA_W-1:0]     mem_wdata;
    logic                  mem_rvalid;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  mem_err;

    modport master (
        output mem_req, mem_addr, mem_we, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata, mem_err
    );

    modport slave (
        input  mem_req, mem_addr, mem_we, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata, mem_err
    );
endinterface

// File: rtl/lsu_mem_if_lane_align.sv
// rtl/lsu_mem_if_lane_align.sv - combinational load data shift and sign/zero extension
// Ports: hi/lo raw beat data, off byte offset, op access type; rdata right-justified result.
module lsu_mem_if_lane_align
    import lsu_mem_if_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] hi,
    input  logic [DATA_W-1:0] lo,
    input  logic [OFF_W-1:0]  off,
    input  mem_op_e           op,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] s;

    // Bytes above off+size never matter: the op truncation below discards them.
    assign s = DATA_W'({hi, lo} >> {off, 3'b000});

    always_comb begin
        rdata = s;
        case (op)
            MEM_BYTE:   rdata = DATA_W'(signed'(s[BYTE_SIZE-1:0]));
            MEM_HALF:   rdata = DATA_W'(signed'(s[HALF_WORD_SIZE-1:0]));
            MEM_WORD:   rdata = DATA_W'(signed'(s[31:0]));
            MEM_BYTE_U: rdata = DATA_W'(s[BYTE_SIZE-1:0]);
            MEM_HALF_U: rdata = DATA_W'(s[HALF_WORD_SIZE-1:0]);
            MEM_WORD_U: rdata = DATA_W'(s[31:0]);
            default:    rdata = s;
        endcase
    end
endmodule

// File: rtl/lsu_mem_if.sv
// rtl/lsu_mem_if.sv - sequential load/store unit between MEM stage and request/grant bus
// Ports: clk, rst (sync active-high); req_valid/req_ready/req_we/req_op/req_addr/req_wdata request;
//        rsp_valid/rsp_rdata/rsp_err/rsp_misaligned response; mem: bus master modport.
module lsu_mem_if
    import lsu_mem_if_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter bit MISALIGN_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  mem_op_e           req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_misaligned,
    lsu_mem_if_if.master      mem
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);

    lsu_state_e        state;
    mem_op_e           op_q;
    logic              we_q;
    logic              split_q;
    logic [OFF_W-1:0]  off_q;
    logic [ADDR_W-1:0] base_q;
    logic [NB-1:0]     be_hi_q;
    logic [DATA_W-1:0] wd_hi_q;
    logic [DATA_W-1:0] lo_q;

    logic              mem_req_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_we_q;
    logic [NB-1:0]     mem_be_q;
    logic [DATA_W-1:0] mem_wdata_q;

    mem_op_e             op_in;
    logic [3:0]          size_in;
    logic [OFF_W-1:0]    off_in;
    logic                split_in;
    logic [2*NB-1:0]     mask_in;
    logic [2*DATA_W-1:0] wd_in;
    logic [DATA_W-1:0]   lo_src;
    logic [DATA_W-1:0]   load_data;

    assign req_ready      = (state == IDLE);
    assign mem.mem_req    = mem_req_q;
    assign mem.mem_addr   = mem_addr_q;
    assign mem.mem_we     = mem_we_q;
    assign mem.mem_be     = mem_be_q;
    assign mem.mem_wdata  = mem_wdata_q;

    // Ops the build cannot perform fall back to a word access.
    always_comb begin
        op_in = MEM_WORD;
        case (req_op)
            MEM_BYTE, MEM_HALF, MEM_WORD,
            MEM_BYTE_U, MEM_HALF_U, MEM_WORD_U: op_in = req_op;
            MEM_DWORD: op_in = (DATA_W == 64) ? MEM_DWORD : MEM_WORD;
            default:   op_in = MEM_WORD;
        endcase
    end

    assign size_in  = mem_op_size(op_in);
    assign off_in   = req_addr[OFF_W-1:0];
    assign split_in = (int'(off_in) + int'(size_in)) > NB;
    // Two-beat lane view: low half is beat 0, high half is beat 1.
    assign mask_in  = (2*NB)'((16'd1 << size_in) - 16'd1) << off_in;
    assign wd_in    = {{DATA_W{1'b0}}, (req_we ? req_wdata : {DATA_W{1'b0}})} << {off_in, 3'b000};

    // On the final beat the newest data comes straight off the bus; the earlier beat
    // (if any) sits in lo_q. Unsplit accesses never reach the high half.
    assign lo_src = (state == WAIT0) ? mem.mem_rdata : lo_q;

    lsu_mem_if_lane_align #(
        .DATA_W (DATA_W),
        .OFF_W  (OFF_W)
    ) u_align (
        .hi     (mem.mem_rdata),
        .lo     (lo_src),
        .off    (off_q),
        .op     (op_q),
        .rdata  (load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            op_q           <= MEM_WORD;
            we_q           <= 1'b0;
            split_q        <= 1'b0;
            off_q          <= '0;
            base_q         <= '0;
            be_hi_q        <= '0;
            wd_hi_q        <= '0;
            lo_q           <= '0;
            mem_req_q      <= 1'b0;
            mem_addr_q     <= '0;
            mem_we_q       <= 1'b0;
            mem_be_q       <= '0;
            mem_wdata_q    <= '0;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= '0;
            rsp_err        <= 1'b0;
            rsp_misaligned <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q    <= op_in;
                        we_q    <= req_we;
                        split_q <= split_in;
                        off_q   <= off_in;
                        base_q  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        be_hi_q <= mask_in[2*NB-1:NB];
                        wd_hi_q <= wd_in[2*DATA_W-1:DATA_W];
                        if (split_in && !MISALIGN_EN) begin
                            state          <= RESP;
                            rsp_valid      <= 1'b1;
                            rsp_rdata      <= '0;
                            rsp_err        <= 1'b0;
                            rsp_misaligned <= 1'b1;
                        end else begin
                            state       <= REQ0;
                            mem_req_q   <= 1'b1;
                            mem_addr_q  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                            mem_we_q    <= req_we;
                            mem_be_q    <= mask_in[NB-1:0];
                            mem_wdata_q <= wd_in[DATA_W-1:0];
                        end
                    end
                end
                REQ0, REQ1: begin
                    if (mem.mem_gnt) begin
                        mem_req_q <= 1'b0;
                        state     <= (state == REQ0) ? WAIT0 : WAIT1;
                    end
                end
                WAIT0: begin
                    if (mem.mem_rvalid) begin
                        lo_q <= mem.mem_rdata;
                        if (!mem.mem_err && split_q) begin
                            state       <= REQ1;
                            mem_req_q   <= 1'b1;
                            mem_addr_q  <= base_q + ADDR_W'(NB);
                            mem_be_q    <= be_hi_q;
                            mem_wdata_q <= wd_hi_q;
                        end else begin
                            state          <= RESP;
                            rsp_valid      <= 1'b1;
                            rsp_err        <= mem.mem_err;
                            rsp_misaligned <= 1'b0;
                            rsp_rdata      <= (mem.mem_err || we_q) ? '0 : load_data;
                        end
                    end
                end
                WAIT1: begin
                    if (mem.mem_rvalid) begin
                        state          <= RESP;
                        rsp_valid      <= 1'b1;
                        rsp_err        <= mem.mem_err;
                        rsp_misaligned <= 1'b0;
                        rsp_rdata      <= (mem.mem_err || we_q) ? '0 : load_data;
                    end
                end
                RESP: begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
